powerup_slot_controller: RTL
============================

// Module: powerup_slot_controller
// PURPOSE
// - Owns one shared power-up slot contested by player 0 and player 1: placement, pickup arbitration, timed effect, expiry.
// - Sits beside the processor's memory-mapped player registers; consumes player x/y, drives slot x/y to video and effect flags to the MMIO read mux.
// - Fixes timing: effect lasts exactly NUM_STAGES*TICK_DIV unpaused cycles.
// PARAMETERS
// - TICK_DIV     100000000  clock cycles per duration stage (>=1)
// - NUM_STAGES   8          stages per effect (1..15)
// - SPRITE_W     24         sprite width, same for players and slot
// - SPRITE_H     24         sprite height
// - SPAWN_X      300        slot x after reset/respawn
// - SPAWN_Y      300        slot y after reset/respawn
// - COOLDOWN_STG 4          stages parked before respawn (POWERUP_RESPAWN_EN only)
// PORTS
// - clock        in   1   master clock, rising edge
// - reset        in   1   synchronous, active-low
// - player0_x    in   32  player 0 x (pixels)
// - player0_y    in   32  player 0 y
// - player1_x    in   32  player 1 x
// - player1_y    in   32  player 1 y
// - pause        in   1   1 = freeze tick/stage counters and pickup detection
// - powerup_x    out  32  slot x; 32'hFFFFFFFF when parked
// - powerup_y    out  32  slot y; 32'hFFFFFFFF when parked
// - effect_p0    out  1   player 0 effect active
// - effect_p1    out  1   player 1 effect active
// - stages_left  out  4   stages remaining in ACTIVE, else 0
// - pickup_evt   out  1   one-cycle pulse on pickup
// - expire_evt   out  1   one-cycle pulse on effect end
// BEHAVIOUR
// - Reset (reset==0 at rising edge): state AVAILABLE, powerup_x/y=SPAWN_X/Y, effect_p0/p1=0, stages_left=0, pulses 0, tick=0, stage=0, rr_prio=player 0. Overrides any state, mid-effect included.
// - Overlap(p): SPAWN-relative AABB, 33-bit unsigned: (slot_x <= p_x+SPRITE_W) && (p_x <= slot_x+SPRITE_W), same for y. Evaluated only in AVAILABLE and pause==0.
// - AVAILABLE: if overlap0|overlap1 -> ACTIVE at next edge; pickup_evt=1 for that cycle; slot parks (x/y=all ones); winner's effect flag=1; stages_left=NUM_STAGES; tick=0.
// - Simultaneous overlap: winner = rr_prio; rr_prio then flips to the loser. Single overlap does not change rr_prio. Loser gets nothing.
// - ACTIVE: tick counts 0..TICK_DIV-1 when pause==0; on tick==TICK_DIV-1, tick->0, stages_left-1. When decrementing from 1: effect flag->0, expire_evt=1, stages_left=0, go PARKED/COOLDOWN.
// - pause==1: tick, stages_left, state hold; outputs hold; no pickups.
// - Latency: pickup 1 cycle after overlap first visible on inputs; expiry exactly NUM_STAGES*TICK_DIV unpaused cycles after pickup edge.
// - Exactly one of effect_p0/effect_p1 ever 1; both 0 outside ACTIVE.
// - Player coordinates near 2^32 must not wrap (33-bit sums).
// CONFIGURATION
// - POWERUP_RESPAWN_EN defined: after expiry enter COOLDOWN (slot parked), count COOLDOWN_STG stages with same tick/pause rules, then AVAILABLE at SPAWN_X/Y; if a player overlaps spawn on respawn cycle, pickup evaluated from the following cycle.
// - Undefined: after expiry enter PARKED, terminal until reset; slot stays at all ones.
// STRUCTURE
// - Package pacman_pkg: slot_state_e {AVAILABLE, ACTIVE, COOLDOWN, PARKED}, PARK_COORD=32'hFFFFFFFF, player id encoding (0/1).
// - Sub-module powerup_stage_timer: tick divider + stage down-counter (load, enable, done pulse), reused for ACTIVE and COOLDOWN.
// - Top: state register, overlap compare, round-robin arbiter, output regs.
// TESTING (bench params TICK_DIV=4, NUM_STAGES=3, COOLDOWN_STG=2, SPAWN=300,300)
// - Reset: reset=0 two cycles -> powerup_x/y=300/300, effects 0, stages_left 0, no pulses.
// - P0 at (310,290), P1 far -> next edge: pickup_evt=1, effect_p0=1, stages_left=3, slot=FFFFFFFF; expire_evt exactly 12 cycles later, effect_p0=0.
// - Both overlap same cycle twice (with reset-free respawn between) -> first win P0, second win P1.
// - pause=1 for 5 cycles mid-ACTIVE -> expiry delayed by exactly 5 cycles; P1 overlapping parked slot never triggers.
// - reset=0 mid-ACTIVE (stages_left=2) -> next edge all outputs at reset values, slot back at 300,300.
// - With POWERUP_RESPAWN_EN: slot reappears at 300,300 exactly 8 cycles after expire_evt; without: stays FFFFFFFF for 100 cycles.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared types and helpers for the power-up slot logic.
//   slot_state_e : lifecycle of the shared power-up slot
//   player_id_e  : player identity (0/1), also used as round-robin priority
//   PARK_COORD   : coordinate driven while the slot is off-screen
//   span_overlap : one-axis AABB test widened to 33 bits so edge sums never wrap
package pacman_pkg;

  typedef enum logic [1:0] {
    AVAILABLE = 2'd0,
    ACTIVE    = 2'd1,
    COOLDOWN  = 2'd2,
    PARKED    = 2'd3
  } slot_state_e;

  typedef enum logic {
    PLAYER0 = 1'b0,
    PLAYER1 = 1'b1
  } player_id_e;

  localparam logic [31:0] PARK_COORD = 32'hFFFF_FFFF;

  // True when [slot, slot+w] and [p, p+w] touch on one axis.
  function automatic logic span_overlap(input logic [31:0] slot,
                                        input logic [31:0] p,
                                        input logic [31:0] w);
    logic [32:0] slot_ext;
    logic [32:0] p_ext;
    logic [32:0] w_ext;
    slot_ext = {1'b0, slot};
    p_ext    = {1'b0, p};
    w_ext    = {1'b0, w};
    return (slot_ext <= (p_ext + w_ext)) && (p_ext <= (slot_ext + w_ext));
  endfunction

  function automatic player_id_e other_player(input player_id_e p);
    return (p == PLAYER0) ? PLAYER1 : PLAYER0;
  endfunction

endpackage

// File: rtl/powerup_slot_controller_if.sv
// Bus between the player-register block / video and the power-up slot.
//   player0_x/y, player1_x/y : player positions (pixels)
//   pause                    : freezes timing and pickup detection
//   powerup_x/y              : slot position, all ones while parked
//   effect_p0/p1             : effect flag per player
//   stages_left              : stages remaining while an effect runs
//   pickup_evt / expire_evt  : one-cycle event pulses
// master drives positions/pause; slave is the slot controller.
interface powerup_slot_controller_if;
  logic [31:0] player0_x;
  logic [31:0] player0_y;
  logic [31:0] player1_x;
  logic [31:0] player1_y;
  logic        pause;
  logic [31:0] powerup_x;
  logic [31:0] powerup_y;
  logic        effect_p0;
  logic        effect_p1;
  logic [3:0]  stages_left;
  logic        pickup_evt;
  logic        expire_evt;

  modport master (
    output player0_x, player0_y, player1_x, player1_y, pause,
    input  powerup_x, powerup_y, effect_p0, effect_p1, stages_left,
           pickup_evt, expire_evt
  );

  modport slave (
    input  player0_x, player0_y, player1_x, player1_y, pause,
    output powerup_x, powerup_y, effect_p0, effect_p1, stages_left,
           pickup_evt, expire_evt
  );
endinterface

// File: rtl/powerup_stage_timer.sv
// Tick divider plus stage down-counter, shared by the effect and cooldown
// phases.
//   clock, reset : rising edge, synchronous active-low reset
//   load         : restart with load_val stages and tick 0 (wins over enable)
//   load_val     : stage count to load
//   enable       : advance the tick divider this cycle
//   count        : stages remaining
//   done         : high in the cycle whose edge retires the last stage
module powerup_stage_timer #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       enable,
  output logic [3:0] count,
  output logic       done
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] tick;

  assign done = enable && (count == 4'd1) && (tick == TICK_LAST);

  always_ff @(posedge clock) begin
    if (!reset) begin
      tick  <= '0;
      count <= '0;
    end else if (load) begin
      tick  <= '0;
      count <= load_val;
    end else if (enable && (count != '0)) begin
      if (tick == TICK_LAST) begin
        tick  <= '0;
        count <= count - 4'd1;
      end else begin
        tick <= tick + TICK_W'(1);
      end
    end
  end

endmodule

// File: rtl/powerup_slot_controller.sv
// Owns the single power-up slot shared by player 0 and player 1: placement
// at the spawn point, pickup arbitration, timed effect and expiry.
//   clock, reset : rising edge, synchronous active-low reset
//   bus (slave)  : player positions and pause in; slot position, effect
//                  flags, stages_left and pickup/expire pulses out
// Build option POWERUP_RESPAWN_EN: after expiry the slot waits COOLDOWN_STG
// stages and respawns at SPAWN_X/Y; without it the slot parks until reset.
module powerup_slot_controller
  import pacman_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 100000000,
  parameter int unsigned NUM_STAGES   = 8,
  parameter int unsigned SPRITE_W     = 24,
  parameter int unsigned SPRITE_H     = 24,
  parameter int unsigned SPAWN_X      = 300,
  parameter int unsigned SPAWN_Y      = 300,
  parameter int unsigned COOLDOWN_STG = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  powerup_slot_controller_if.slave   bus
);

`ifdef POWERUP_RESPAWN_EN
  localparam bit RESPAWN_EN = 1'b1;
`else
  localparam bit RESPAWN_EN = 1'b0;
`endif

  localparam logic [31:0] SPAWN_X32   = 32'(SPAWN_X);
  localparam logic [31:0] SPAWN_Y32   = 32'(SPAWN_Y);
  localparam logic [31:0] SPRITE_W32  = 32'(SPRITE_W);
  localparam logic [31:0] SPRITE_H32  = 32'(SPRITE_H);
  localparam logic [3:0]  EFFECT_LOAD = 4'(NUM_STAGES);
  localparam logic [3:0]  COOL_LOAD   = 4'(COOLDOWN_STG);

  slot_state_e state_q, state_d;
  player_id_e  rr_q, rr_d;
  player_id_e  winner;
  logic [31:0] slot_x_q, slot_x_d;
  logic [31:0] slot_y_q, slot_y_d;
  logic        eff0_q, eff0_d;
  logic        eff1_q, eff1_d;
  logic        pick_q, pick_d;
  logic        exp_q, exp_d;

  logic        ov0, ov1;
  logic        tmr_load, tmr_en, tmr_done;
  logic [3:0]  tmr_load_val, tmr_count;

  // Overlap is always tested against the spawn point: the slot is only
  // ever collectable while sitting there.
  assign ov0 = span_overlap(SPAWN_X32, bus.player0_x, SPRITE_W32) &&
               span_overlap(SPAWN_Y32, bus.player0_y, SPRITE_H32);
  assign ov1 = span_overlap(SPAWN_X32, bus.player1_x, SPRITE_W32) &&
               span_overlap(SPAWN_Y32, bus.player1_y, SPRITE_H32);

  assign tmr_en = !bus.pause && ((state_q == ACTIVE) || (state_q == COOLDOWN));

  powerup_stage_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .enable   (tmr_en),
    .count    (tmr_count),
    .done     (tmr_done)
  );

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    winner       = rr_q;
    slot_x_d     = slot_x_q;
    slot_y_d     = slot_y_q;
    eff0_d       = eff0_q;
    eff1_d       = eff1_q;
    pick_d       = 1'b0;
    exp_d        = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = EFFECT_LOAD;

    case (state_q)
      AVAILABLE: begin
        if (!bus.pause && (ov0 || ov1)) begin
          if (ov0 && ov1) begin
            winner = rr_q;
            rr_d   = other_player(rr_q);
          end else begin
            winner = ov0 ? PLAYER0 : PLAYER1;
          end
          state_d      = ACTIVE;
          slot_x_d     = PARK_COORD;
          slot_y_d     = PARK_COORD;
          eff0_d       = (winner == PLAYER0);
          eff1_d       = (winner == PLAYER1);
          pick_d       = 1'b1;
          tmr_load     = 1'b1;
          tmr_load_val = EFFECT_LOAD;
        end
      end
      ACTIVE: begin
        if (tmr_done) begin
          eff0_d = 1'b0;
          eff1_d = 1'b0;
          exp_d  = 1'b1;
          if (RESPAWN_EN) begin
            state_d      = COOLDOWN;
            tmr_load     = 1'b1;
            tmr_load_val = COOL_LOAD;
          end else begin
            state_d = PARKED;
          end
        end
      end
      COOLDOWN: begin
        if (tmr_done) begin
          state_d  = AVAILABLE;
          slot_x_d = SPAWN_X32;
          slot_y_d = SPAWN_Y32;
        end
      end
      PARKED: begin
        state_d = PARKED;
      end
      default: begin
        state_d = AVAILABLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= AVAILABLE;
      rr_q     <= PLAYER0;
      slot_x_q <= SPAWN_X32;
      slot_y_q <= SPAWN_Y32;
      eff0_q   <= 1'b0;
      eff1_q   <= 1'b0;
      pick_q   <= 1'b0;
      exp_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      slot_x_q <= slot_x_d;
      slot_y_q <= slot_y_d;
      eff0_q   <= eff0_d;
      eff1_q   <= eff1_d;
      pick_q   <= pick_d;
      exp_q    <= exp_d;
    end
  end

  assign bus.powerup_x   = slot_x_q;
  assign bus.powerup_y   = slot_y_q;
  assign bus.effect_p0   = eff0_q;
  assign bus.effect_p1   = eff1_q;
  assign bus.pickup_evt  = pick_q;
  assign bus.expire_evt  = exp_q;
  assign bus.stages_left = (state_q == ACTIVE) ? tmr_count : '0;

endmodule
